lsclk_monitor: RTL

Receive-side companion to the low-speed clock generator. It takes the divided sampling clock as an asynchronous input and synchronizes it into the fast `clk` domain. It emits single-cycle rise/fall strobes for fast-domain logic, measures period and high time in `clk` cycles, and reports lock and loss-of-clock status. It sits in the fast domain next to the ADC/filter control logic, which consumes `o_rise_stb` as its sample tick.

---
 rtl/lsclk_pkg.sv | 11 +
 rtl/lsclk_monitor_edge_sync.sv | 32 +++
 rtl/lsclk_monitor.sv | 111 +++++++++++
 3 files changed

// File: rtl/lsclk_pkg.sv
// Shared definitions for the low-speed clock generator / monitor pair.
package lsclk_pkg;
  localparam int LSCLK_NB_COUNTER = 11;
  localparam int LSCLK_EXP_PERIOD = 900;  // must track the generator's COUNT_LIM

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_LOST = 2'd2
  } mon_state_t;
endpackage

// File: rtl/lsclk_monitor_edge_sync.sv
// Two-flop synchronizer plus history flop for one asynchronous input.
// Raw edges are combinational; the strobes are the same edges registered once.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_stb,
  output logic o_fall_stb
);
  logic r_q1, r_q2, r_q3;

  assign o_rise = r_q2 & ~r_q3;
  assign o_fall = ~r_q2 & r_q3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q1       <= 1'b0;
      r_q2       <= 1'b0;
      r_q3       <= 1'b0;
      o_rise_stb <= 1'b0;
      o_fall_stb <= 1'b0;
    end else begin
      r_q1       <= i_async;
      r_q2       <= r_q1;
      r_q3       <= r_q2;
      o_rise_stb <= o_rise;
      o_fall_stb <= o_fall;
    end
  end
endmodule

// File: rtl/lsclk_monitor.sv
// Fast-domain monitor for the divided sampling clock: edge strobes,
// period/high-time measurement, lock and loss-of-clock status.
module lsclk_monitor
  import lsclk_pkg::*;
#(
  parameter int NB_COUNTER = LSCLK_NB_COUNTER,
  parameter int EXP_PERIOD = LSCLK_EXP_PERIOD,
  parameter int TOLERANCE  = 4,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 1800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_slow_clk,
  output logic                  o_rise_stb,
  output logic                  o_fall_stb,
  output logic [NB_COUNTER-1:0] o_period,
  output logic [NB_COUNTER-1:0] o_high,
  output logic                  o_meas_valid,
  output logic                  o_locked,
  output logic                  o_lost
);
  localparam int NB_G = $clog2(LOCK_COUNT + 1);
  localparam logic [NB_COUNTER:0]   LP_EXP  = (NB_COUNTER+1)'(EXP_PERIOD);
  localparam logic [NB_COUNTER:0]   LP_TOL  = (NB_COUNTER+1)'(TOLERANCE);
  localparam logic [NB_COUNTER-1:0] LP_TMO  = NB_COUNTER'(TIMEOUT - 1);
  localparam logic [NB_G-1:0]       LP_LOCK = NB_G'(LOCK_COUNT);

  logic                  w_rise, w_fall, w_good, w_tmo;
  logic [NB_COUNTER:0]   w_len, w_diff;
  logic [NB_G-1:0]       w_gcnt_inc;
  logic [NB_COUNTER-1:0] r_cnt;
  logic [NB_G-1:0]       r_gcnt;
  mon_state_t            r_state;

  edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_async   (i_slow_clk),
    .o_rise    (w_rise),
    .o_fall    (w_fall),
    .o_rise_stb(o_rise_stb),
    .o_fall_stb(o_fall_stb)
  );

  // One extra bit so |len - EXP| never underflows.
  assign w_len      = {1'b0, r_cnt} + (NB_COUNTER+1)'(1);
  assign w_diff     = (w_len >= LP_EXP) ? (w_len - LP_EXP) : (LP_EXP - w_len);
  assign w_good     = (w_diff <= LP_TOL);
  assign w_tmo      = (r_cnt == LP_TMO);
  assign w_gcnt_inc = (r_gcnt == LP_LOCK) ? r_gcnt : r_gcnt + NB_G'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (w_rise) r_cnt <= '0;
    else             r_cnt <= r_cnt + NB_COUNTER'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_WAIT;
      r_gcnt       <= '0;
      o_period     <= '0;
      o_high       <= '0;
      o_meas_valid <= 1'b0;
      o_locked     <= 1'b0;
      o_lost       <= 1'b0;
    end else begin
      o_meas_valid <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (w_rise) begin
            r_state <= S_RUN;
          end else if (w_tmo) begin
            r_state  <= S_LOST;
            o_lost   <= 1'b1;
            o_locked <= 1'b0;
            r_gcnt   <= '0;
          end
        end
        S_RUN: begin
          // A rise on the timeout cycle still measures (and is judged bad).
          if (w_rise) begin
            o_period     <= w_len[NB_COUNTER-1:0];
            o_meas_valid <= 1'b1;
            if (w_good) begin
              r_gcnt   <= w_gcnt_inc;
              o_locked <= (w_gcnt_inc == LP_LOCK);
            end else begin
              r_gcnt   <= '0;
              o_locked <= 1'b0;
            end
          end else if (w_tmo) begin
            r_state  <= S_LOST;
            o_lost   <= 1'b1;
            o_locked <= 1'b0;
            r_gcnt   <= '0;
          end
          if (w_fall) o_high <= w_len[NB_COUNTER-1:0];
        end
        S_LOST: begin
          if (w_rise) begin
            r_state <= S_RUN;
            o_lost  <= 1'b0;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end
endmodule
